// File: rtl/calfifo_pkg.sv
// calfifo_pkg
// Shared definitions for the calibration FIFO:
//   clog2        - ceiling log2, used to size pointers and the fill count
//   RD_LAT_STD   - cycles from an accepted read to Q/DVLD in standard mode
//   RD_LAT_FWFT  - cycles from a write into an empty FIFO to a valid head in FWFT mode
//   mode_e       - read-mode selector derived from the FWFT parameter
package calfifo_pkg;

  localparam int RD_LAT_STD  = 2;
  localparam int RD_LAT_FWFT = 2;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } mode_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/calfifo_ram.sv
// calfifo_ram
// Simple dual-port DEPTH x WIDTH memory: one write port, one read port with a
// registered output (1-cycle latency). The output register holds its value
// while rd_en_i is low, which the FWFT prefetch stage relies on.
// Ports:
//   clk_i      clock
//   wr_en_i    write enable
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read enable (loads rd_data_o on the next edge)
//   rd_addr_i  read address
//   rd_data_o  registered read data
module calfifo_ram #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/calfifo_sync.sv
// calfifo_sync
// Single-clock calibration FIFO with configurable width/depth and a standard
// (registered, 2-cycle read latency) or first-word-fall-through read mode.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   DATA, WE              write data and request
//   RE                    read request (standard) / pop (FWFT)
//   AF_THRESH, AE_THRESH  runtime almost-full / almost-empty thresholds
//   Q, DVLD               read data; valid strobe (standard) or head valid (FWFT)
//   FULL, EMPTY           capacity flags
//   AFULL, AEMPTY         threshold flags
//   WRCNT                 words held (including any prefetched words)
//   OVERFLOW, UNDERFLOW   one-cycle pulses for rejected writes / reads
module calfifo_sync
  import calfifo_pkg::*;
#(
  parameter int  WIDTH = 12,
  parameter int  DEPTH = 512,
  parameter int  FWFT  = 0,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA,
  input  logic             WE,
  input  logic             RE,
  input  logic [AW:0]      AF_THRESH,
  input  logic [AW:0]      AE_THRESH,
  output logic [WIDTH-1:0] Q,
  output logic             DVLD,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic [AW:0]      WRCNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam mode_e       MODE    = (FWFT != 0) ? MODE_FWFT : MODE_STD;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
  logic             dvld_q;
  logic [WIDTH-1:0] q_q;
  logic             wr_ok, rd_ok, fetch;
  logic [WIDTH-1:0] ram_rdata;

  // Acceptance uses the registered flags so a request is judged on the state
  // the requester could observe before the edge.
  assign wr_ok   = WE & ~full_q;
  assign rd_ok   = RE & ~empty_q;
  assign count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= (AF_THRESH == '0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (fetch) rptr_q <= rptr_q + AW'(1);
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      afull_q  <= (count_d >= AF_THRESH);
      aempty_q <= (count_d <= AE_THRESH);
      ovf_q    <= WE & full_q;
      udf_q    <= RE & empty_q;
    end
  end

  calfifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (CLK),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wptr_q),
    .wr_data_i (DATA),
    .rd_en_i   (fetch),
    .rd_addr_i (rptr_q),
    .rd_data_o (ram_rdata)
  );

  if (MODE == MODE_STD) begin : g_std
    // RAM read at the accepting edge, staged once, then loaded into Q, so
    // Q/DVLD appear RD_LAT_STD edges after the request edge.
    logic [RD_LAT_STD-1:0] vpipe_q;
    logic [WIDTH-1:0]      stage_q;

    assign fetch = rd_ok;

    always_ff @(posedge CLK) begin
      if (vpipe_q[0]) stage_q <= ram_rdata;
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        vpipe_q <= '0;
        dvld_q  <= 1'b0;
        q_q     <= '0;
        empty_q <= 1'b1;
      end else begin
        vpipe_q <= {vpipe_q[RD_LAT_STD-2:0], rd_ok};
        dvld_q  <= vpipe_q[RD_LAT_STD-1];
        if (vpipe_q[RD_LAT_STD-1]) q_q <= stage_q;
        empty_q <= (count_d == '0);
      end
    end
  end else begin : g_fwft
    // Two-entry prefetch: the RAM output register (valid = pf_v_q) feeds the
    // head register Q (valid = dvld_q). ram_cnt_q counts words still in RAM,
    // separate from WRCNT which also includes the two prefetch slots.
    logic        pf_v_q;
    logic [AW:0] ram_cnt_q;
    logic        move, head_v_d;

    assign move     = pf_v_q & (~dvld_q | rd_ok);
    assign fetch    = (ram_cnt_q != '0) & (~pf_v_q | move);
    assign head_v_d = move | (dvld_q & ~rd_ok);

    always_ff @(posedge CLK) begin
      if (RESET) begin
        pf_v_q    <= 1'b0;
        ram_cnt_q <= '0;
        dvld_q    <= 1'b0;
        q_q       <= '0;
        empty_q   <= 1'b1;
      end else begin
        ram_cnt_q <= ram_cnt_q + (AW+1)'(wr_ok) - (AW+1)'(fetch);
        pf_v_q    <= fetch | (pf_v_q & ~move);
        if (move) q_q <= ram_rdata;
        dvld_q    <= head_v_d;
        empty_q   <= ~head_v_d;
      end
    end
  end

  assign Q         = q_q;
  assign DVLD      = dvld_q;
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign WRCNT     = count_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_calfifo_sync.sv
module tb_calfifo_sync;

  localparam int W   = 12;
  localparam int D   = 512;
  localparam int FW  = 16;
  localparam int FD  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance (defaults)
  logic          s_rst = 1'b1, s_we = 1'b0, s_re = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic [9:0]    s_af = '0, s_ae = 10'd4;
  logic [W-1:0]  s_q;
  logic          s_dvld, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic [9:0]    s_wrcnt;

  // FWFT instance
  logic          f_rst = 1'b1, f_we = 1'b0, f_re = 1'b0;
  logic [FW-1:0] f_data = '0;
  logic [6:0]    f_af = 7'd60, f_ae = 7'd3;
  logic [FW-1:0] f_q;
  logic          f_dvld, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [6:0]    f_wrcnt;

  calfifo_sync u_std (
    .CLK(clk), .RESET(s_rst), .DATA(s_data), .WE(s_we), .RE(s_re),
    .AF_THRESH(s_af), .AE_THRESH(s_ae), .Q(s_q), .DVLD(s_dvld),
    .FULL(s_full), .EMPTY(s_empty), .AFULL(s_afull), .AEMPTY(s_aempty),
    .WRCNT(s_wrcnt), .OVERFLOW(s_ovf), .UNDERFLOW(s_udf)
  );

  calfifo_sync #(.WIDTH(FW), .DEPTH(FD), .FWFT(1)) u_fwft (
    .CLK(clk), .RESET(f_rst), .DATA(f_data), .WE(f_we), .RE(f_re),
    .AF_THRESH(f_af), .AE_THRESH(f_ae), .Q(f_q), .DVLD(f_dvld),
    .FULL(f_full), .EMPTY(f_empty), .AFULL(f_afull), .AEMPTY(f_aempty),
    .WRCNT(f_wrcnt), .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard-mode reference: queue of stored words plus a list of reads in
  // flight, each due RD latency (2) edges after it was accepted.
  typedef struct {
    logic [W-1:0] d;
    int           due;
  } rd_t;

  logic [W-1:0] m_fifo[$];
  rd_t          m_pend[$];
  int           cyc = 0;
  logic [W-1:0] m_q = '0;
  logic         m_dvld = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  task automatic tick_s();
    bit  full_b, empty_b, wok, rok;
    rd_t e;
    @(posedge clk);
    cyc++;
    if (s_rst) begin
      m_fifo.delete();
      m_pend.delete();
      m_q = '0; m_dvld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      full_b  = (m_fifo.size() == D);
      empty_b = (m_fifo.size() == 0);
      wok = s_we && !full_b;
      rok = s_re && !empty_b;
      m_ovf = s_we && full_b;
      m_udf = s_re && empty_b;
      if (rok) begin
        e.d = m_fifo.pop_front();
        e.due = cyc + 2;
        m_pend.push_back(e);
      end
      if (wok) m_fifo.push_back(s_data);
      m_dvld = 1'b0;
      if (m_pend.size() > 0 && m_pend[0].due == cyc) begin
        m_dvld = 1'b1;
        m_q = m_pend[0].d;
        void'(m_pend.pop_front());
      end
    end
    #1;
    check("s_wrcnt",  s_wrcnt,  m_fifo.size());
    check("s_full",   s_full,   m_fifo.size() == D);
    check("s_empty",  s_empty,  m_fifo.size() == 0);
    check("s_afull",  s_afull,  m_fifo.size() >= s_af);
    check("s_aempty", s_aempty, m_fifo.size() <= s_ae);
    check("s_ovf",    s_ovf,    m_ovf);
    check("s_udf",    s_udf,    m_udf);
    check("s_dvld",   s_dvld,   m_dvld);
    check("s_q",      s_q,      m_q);
  endtask

  // FWFT reference: scoreboard of words held; a pop happens whenever RE is
  // high while a head word is presented, and must return the oldest word.
  logic [FW-1:0] f_sb[$];
  int            f_stall = 0;

  task automatic tick_f();
    bit full_b, wok, ovf_exp, pop;
    full_b  = (f_sb.size() == FD);
    wok     = f_we && !full_b;
    ovf_exp = f_we && full_b;
    pop     = f_re && f_dvld;
    if (pop) begin
      check("f_pop_has_word", f_sb.size() != 0, 1'b1);
      if (f_sb.size() != 0) check("f_data", f_q, f_sb.pop_front());
    end
    @(posedge clk);
    if (f_rst) begin
      f_sb.delete();
      ovf_exp = 1'b0;
    end else if (wok) begin
      f_sb.push_back(f_data);
    end
    #1;
    check("f_wrcnt",  f_wrcnt,  f_sb.size());
    check("f_full",   f_full,   f_sb.size() == FD);
    check("f_afull",  f_afull,  f_sb.size() >= f_af);
    check("f_aempty", f_aempty, f_sb.size() <= f_ae);
    check("f_ovf",    f_ovf,    ovf_exp);
    if (f_sb.size() > 0 && !f_dvld) f_stall++;
    else f_stall = 0;
    check("f_head_latency", f_stall <= 4, 1'b1);
  endtask

  int nextw, guard;
  bit up, acc;

  initial begin
    // ---------------- standard mode ----------------
    s_rst = 1'b1; s_af = '0; s_ae = 10'd4;
    tick_s(); tick_s();
    check("rst_empty", s_empty, 1'b1);
    check("rst_afull_thr0", s_afull, 1'b1);
    check("rst_q", s_q, 0);
    s_rst = 1'b0; s_af = 10'd500;
    tick_s();

    // fill to 512 then overflow
    for (int i = 0; i < D; i++) begin
      s_we = 1'b1; s_data = W'($urandom);
      tick_s();
    end
    check("fill_full", s_full, 1'b1);
    check("fill_cnt", s_wrcnt, 512);
    s_data = 12'hABC;
    tick_s();
    check("ovf_pulse", s_ovf, 1'b1);
    check("ovf_cnt", s_wrcnt, 512);
    s_we = 1'b0;
    tick_s();
    check("ovf_one_cycle", s_ovf, 1'b0);

    // RE+WE while full: read wins, write rejected
    s_we = 1'b1; s_re = 1'b1; s_data = 12'h111;
    tick_s();
    check("full_rw_cnt", s_wrcnt, 511);
    check("full_rw_ovf", s_ovf, 1'b1);
    s_re = 1'b0; s_data = 12'h222;
    tick_s();
    check("full_refill", s_wrcnt, 512);
    s_we = 1'b0;

    // drain to 256, then simultaneous access for 100 cycles
    s_re = 1'b1;
    repeat (256) tick_s();
    s_re = 1'b0;
    repeat (3) tick_s();
    s_we = 1'b1; s_re = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = W'($urandom);
      tick_s();
    end
    check("simul_cnt", s_wrcnt, 256);
    s_we = 1'b0;
    repeat (256) tick_s();
    s_re = 1'b0;
    repeat (3) tick_s();

    // read latency
    s_we = 1'b1; s_data = 12'h0A5;
    tick_s();
    s_we = 1'b0; s_re = 1'b1;
    tick_s();
    s_re = 1'b0;
    tick_s();
    check("lat_n1_dvld", s_dvld, 1'b0);
    tick_s();
    check("lat_n2_dvld", s_dvld, 1'b1);
    check("lat_n2_q", s_q, 12'h0A5);
    tick_s();
    check("lat_n3_dvld", s_dvld, 1'b0);

    // read on empty
    s_re = 1'b1;
    tick_s();
    check("udf_pulse", s_udf, 1'b1);
    s_re = 1'b0;
    repeat (3) tick_s();

    // random stream with thresholds, 1500 incrementing words
    s_af = 10'd500; s_ae = 10'd4;
    nextw = 0; guard = 0; up = 1'b1;
    while (nextw < 1500 && guard < 20000) begin
      if (up && m_fifo.size() >= 505) up = 1'b0;
      else if (!up && m_fifo.size() <= 2) up = 1'b1;
      s_we = up ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 2);
      s_re = up ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 9);
      s_data = W'(nextw);
      acc = s_we && (m_fifo.size() < D);
      tick_s();
      if (acc) nextw++;
      guard++;
    end
    check("stream_words_written", nextw, 1500);
    s_we = 1'b0; s_re = 1'b1; guard = 0;
    while (m_fifo.size() > 0 && guard < 2000) begin
      tick_s();
      guard++;
    end
    s_re = 1'b0;
    repeat (3) tick_s();
    check("stream_drained", s_wrcnt, 0);

    // reset with two reads in flight
    s_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = W'($urandom);
      tick_s();
    end
    s_we = 1'b0; s_re = 1'b1;
    tick_s(); tick_s();
    s_rst = 1'b1;
    tick_s();
    check("midrst_dvld", s_dvld, 1'b0);
    check("midrst_cnt", s_wrcnt, 0);
    check("midrst_empty", s_empty, 1'b1);
    check("midrst_q", s_q, 0);
    s_rst = 1'b0; s_re = 1'b0;
    repeat (4) tick_s();
    s_we = 1'b1; s_data = 12'h3C3;
    tick_s();
    s_we = 1'b0; s_re = 1'b1;
    tick_s();
    s_re = 1'b0;
    tick_s(); tick_s();
    check("post_rst_dvld", s_dvld, 1'b1);
    check("post_rst_q", s_q, 12'h3C3);
    tick_s();

    // ---------------- FWFT mode ----------------
    f_rst = 1'b1;
    tick_f();
    check("f_rst_empty", f_empty, 1'b1);
    check("f_rst_dvld", f_dvld, 1'b0);
    check("f_rst_q", f_q, 0);
    f_rst = 1'b0;
    tick_f();

    f_re = 1'b1;
    tick_f();
    check("f_udf", f_udf, 1'b1);
    f_re = 1'b0;
    tick_f();
    check("f_udf_one_cycle", f_udf, 1'b0);

    f_we = 1'b1; f_data = 16'h1234;
    tick_f();
    f_we = 1'b0;
    check("f_w_empty_n", f_empty, 1'b1);
    tick_f();
    check("f_w_empty_n1", f_empty, 1'b1);
    tick_f();
    check("f_w_empty_n2", f_empty, 1'b0);
    check("f_w_dvld_n2", f_dvld, 1'b1);
    check("f_w_q_n2", f_q, 16'h1234);
    tick_f();
    check("f_w_q_hold", f_q, 16'h1234);
    f_re = 1'b1;
    tick_f();
    f_re = 1'b0;
    check("f_pop_empty", f_empty, 1'b1);
    check("f_pop_cnt", f_wrcnt, 0);
    tick_f();

    up = 1'b1;
    for (int i = 0; i < 900; i++) begin
      if (up && f_sb.size() == FD && $urandom_range(0, 3) == 0) up = 1'b0;
      else if (!up && f_sb.size() == 0) up = 1'b1;
      f_we = up ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 2);
      f_re = up ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 9);
      f_data = FW'($urandom);
      tick_f();
    end
    f_we = 1'b0; f_re = 1'b1; guard = 0;
    while (f_sb.size() > 0 && guard < 300) begin
      tick_f();
      guard++;
    end
    f_re = 1'b0;
    repeat (3) tick_f();
    check("f_drained", f_wrcnt, 0);
    check("f_drained_empty", f_empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calfifo_sync.md
Name: calfifo_sync

Overview:
Parametrised single-clock calibration FIFO. It is the successor to the fixed 12-bit x 512 calibration FIFO, with configurable width and depth and a selectable standard or FWFT read mode. It adds runtime almost-full/almost-empty thresholds, a fill count, overflow/underflow pulses and a read-data-valid strobe. It sits between the calibration sample producers and the calibration sequencer/packetiser in the single CLK domain.

Parameters:
WIDTH, 12, data word width in bits (1..64)
DEPTH, 512, capacity in words; must be a power of 2, 4..4096
FWFT, 0, 0 = standard mode (registered 2-cycle read latency); 1 = first-word-fall-through
AW, clog2(DEPTH), derived; not overridable

Ports:
CLK  in  1  system clock; all logic on the rising edge
RESET  in  1  synchronous reset, active-high
DATA  in  WIDTH  write data
WE  in  1  write request, active-high
RE  in  1  read request (standard mode) or pop (FWFT mode), active-high
AF_THRESH  in  AW+1  almost-full threshold, sampled every cycle
AE_THRESH  in  AW+1  almost-empty threshold, sampled every cycle
Q  out  WIDTH  read data
DVLD  out  1  Q valid strobe (standard mode) or head valid level (FWFT mode)
FULL  out  1  count == DEPTH
EMPTY  out  1  no word is available to read
AFULL  out  1  count >= AF_THRESH
AEMPTY  out  1  count <= AE_THRESH
WRCNT  out  AW+1  words held: written and not yet popped
OVERFLOW  out  1  one-cycle pulse on a rejected write
UNDERFLOW  out  1  one-cycle pulse on a rejected read

Behaviour:
- Reset (RESET high at an edge):
  - Pointers, count and the prefetch/pipeline valid bits are cleared.
  - Q=0, DVLD=0, FULL=0, EMPTY=1, AFULL=(AF_THRESH==0), AEMPTY=1, WRCNT=0, OVERFLOW=0, UNDERFLOW=0.
  - In-flight reads are discarded; no DVLD is issued after reset.
- Acceptance is decided on the registered flag values at the edge:
  - wr_ok = WE & ~FULL
  - rd_ok = RE & ~EMPTY
  - WE & FULL -> OVERFLOW=1 next cycle; data dropped; state unchanged.
  - RE & EMPTY -> UNDERFLOW=1 next cycle; no DVLD; Q holds.
- Count update: WRCNT_next = WRCNT + wr_ok - rd_ok.
  - Simultaneous wr_ok and rd_ok leaves the count unchanged.
  - When FULL, a simultaneous RE+WE accepts the read and rejects the write (OVERFLOW pulses).
- FULL, AFULL, AEMPTY and WRCNT are registered and all derived from WRCNT_next, so they change together one edge after the causing request.
- Threshold changes take effect on the next edge. AF_THRESH > DEPTH means AFULL never asserts.
- Pointers are AW bits and wrap modulo DEPTH without gaps. Read order equals write order across any number of wraps.
- Standard mode (FWFT=0):
  - rd_ok at edge n: RAM read registered at n+1; Q and DVLD=1 at n+2.
  - DVLD is high for exactly one cycle per accepted read; Q holds its value otherwise.
  - EMPTY = (WRCNT==0_next), registered.
  - Back-to-back RE gives one word per cycle with no bubbles.
- FWFT mode (FWFT=1):
  - Internal prefetch fills the output register; DVLD = ~EMPTY, and Q shows the head word whenever DVLD=1.
  - Write into an empty FIFO at edge n: EMPTY=0, DVLD=1, Q=word after edge n+2.
  - rd_ok pops the head. The next word is presented on the following cycle if it has been resident in RAM for at least 1 cycle; otherwise EMPTY rises until it arrives.
  - WRCNT includes prefetched words. FULL still means total == DEPTH.
- Data path is not reset except Q; RAM contents are undefined after reset.

Decomposition:
- Package calfifo_pkg holds:
  - clog2 function
  - read-latency constants RD_LAT_STD=2 and RD_LAT_FWFT=2
  - the mode enum
- Sub-module calfifo_ram: simple dual-port DEPTH x WIDTH with one write port and a registered read port (1-cycle latency), inferable to PolarFire LSRAM/uSRAM.
- Control, flags and the FWFT prefetch stage live in calfifo_sync.

Test Plan:
- Fill and overflow (defaults): 512 writes -> FULL=1 and WRCNT=512 one edge after the 512th write. 513th write -> OVERFLOW pulse for 1 cycle and WRCNT stays 512.
- Read latency (standard): write 12'h0A5 then RE at edge n -> Q=12'h0A5 and DVLD=1 at n+2 only. RE on empty -> UNDERFLOW pulse, no DVLD.
- Simultaneous access: hold WRCNT=256, assert WE+RE for 100 cycles -> WRCNT stays 256, output sequence in order. At FULL, RE+WE -> WRCNT=511 then 512 restored next cycle only on a fresh write.
- Wrap-around and thresholds: AF_THRESH=500, AE_THRESH=4, stream 1500 incrementing words with random RE/WE -> data matches the scoreboard. AFULL rises when WRCNT reaches 500; AEMPTY falls when WRCNT reaches 5.
- FWFT (FWFT=1, WIDTH=16, DEPTH=64): single write of 16'h1234 into empty -> EMPTY=0 and Q=16'h1234 two edges later with no RE. A pop returns EMPTY=1 the next cycle.
- Reset mid-operation: RESET during a streaming read with 2 reads in flight -> no DVLD afterwards, WRCNT=0, EMPTY=1, Q=0. The first post-reset write/read returns the new data.
